quad_encoder_tx: RTL and testbench



---
 rtl/quad_encoder_tx_pkg.sv | 30 +++
 rtl/quad_encoder_tx_if.sv | 23 ++
 rtl/quad_encoder_tx_phase_timer.sv | 31 +++
 rtl/quad_encoder_tx.sv | 94 +++++++++
 tb/tb_quad_encoder_tx.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/quad_encoder_tx_pkg.sv
// Shared definitions for the quadrature encoder emulator: FSM states and A/B phase tables.
// The reader imports the same tables so both ends agree on phase order.
package quad_encoder_tx_pkg;

  localparam int unsigned POS_W = 5;
  localparam int unsigned AB_W  = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PH1   = 3'd1,
    PH2   = 3'd2,
    PH3   = 3'd3,
    DWELL = 3'd4
  } state_e;

  // bit1 = A, bit0 = B
  typedef struct packed {
    logic a;
    logic b;
  } ab_t;

  localparam logic [AB_W-1:0] CW_AB  [0:3] = '{2'b10, 2'b00, 2'b01, 2'b11};
  localparam logic [AB_W-1:0] CCW_AB [0:3] = '{2'b01, 2'b00, 2'b10, 2'b11};
  localparam logic [AB_W-1:0] AB_DETENT    = 2'b11;

  function automatic ab_t phase_ab(input logic dir, input logic [1:0] idx);
    return dir ? ab_t'(CW_AB[idx]) : ab_t'(CCW_AB[idx]);
  endfunction

endpackage

// File: rtl/quad_encoder_tx_if.sv
// Step handshake and quadrature output bundle of the encoder emulator.
interface quad_encoder_tx_if;
  import quad_encoder_tx_pkg::*;

  logic             step_valid;
  logic             step_dir;
  logic             step_ready;
  logic             A;
  logic             B;
  logic             busy;
  logic [POS_W-1:0] pos;

  modport master (
    output step_valid, step_dir,
    input  step_ready, A, B, busy, pos
  );

  modport slave (
    input  step_valid, step_dir,
    output step_ready, A, B, busy, pos
  );

endinterface

// File: rtl/quad_encoder_tx_phase_timer.sv
// Loadable down-counter timing each phase; expired is registered alongside the count.
module quad_encoder_tx_phase_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic         expired_q;

  // expired_q tracks (cnt_q == 0) without a compare on the output path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_q <= 1'b1;
    end else if (load_i) begin
      cnt_q     <= value_i;
      expired_q <= (value_i == '0);
    end else if (cnt_q != '0) begin
      cnt_q     <= cnt_q - W'(1);
      expired_q <= (cnt_q == W'(1));
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/quad_encoder_tx.sv
// Quadrature encoder emulator: turns CW/CCW step requests into detented A/B Gray sequences
// and tracks the mod-(POS_MAX+1) shaft position the quadrature reader reports.
module quad_encoder_tx
  import quad_encoder_tx_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 50000,
  parameter int unsigned DWELL_CYCLES = 100000,
  parameter int unsigned POS_MAX      = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  quad_encoder_tx_if.slave  bus
);

  localparam int unsigned MAX_CYC = (PHASE_CYCLES > DWELL_CYCLES) ? PHASE_CYCLES : DWELL_CYCLES;
  localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  ab_t              ab_q, ab_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_expired;
  logic             accept;

  assign accept = bus.step_valid && (state_q == IDLE);

  quad_encoder_tx_phase_timer #(.W(TMR_W)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmr_load),
    .value_i   (tmr_val),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      ab_q    <= ab_t'(AB_DETENT);
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      ab_q    <= ab_d;
      pos_q   <= pos_d;
    end
  end

  // Next state; any unlisted encoding falls back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)      state_d = PH1;
      PH1:     if (tmr_expired) state_d = PH2;
      PH2:     if (tmr_expired) state_d = PH3;
      PH3:     if (tmr_expired) state_d = DWELL;
      DWELL:   if (tmr_expired) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // A/B, direction latch, timer reload and position wrap, all keyed off the state being entered
  always_comb begin
    dir_d    = dir_q;
    ab_d     = ab_t'(AB_DETENT);
    pos_d    = pos_q;
    tmr_load = (state_d != state_q);
    tmr_val  = TMR_W'(PHASE_CYCLES - 1);

    if (accept) dir_d = bus.step_dir;

    case (state_d)
      PH1:     ab_d = phase_ab(dir_d, 2'd0);
      PH2:     ab_d = phase_ab(dir_d, 2'd1);
      PH3:     ab_d = phase_ab(dir_d, 2'd2);
      DWELL:   tmr_val = TMR_W'(DWELL_CYCLES - 1);
      default: ab_d = ab_t'(AB_DETENT);
    endcase

    if ((state_q == PH3) && (state_d == DWELL)) begin
      if (dir_q) pos_d = (pos_q == POS_W'(POS_MAX)) ? '0 : pos_q + POS_W'(1);
      else       pos_d = (pos_q == '0) ? POS_W'(POS_MAX) : pos_q - POS_W'(1);
    end
  end

  assign bus.step_ready = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.A          = ab_q.a;
  assign bus.B          = ab_q.b;
  assign bus.pos        = pos_q;

endmodule

// File: tb/tb_quad_encoder_tx.sv
// Directed bench for quad_encoder_tx with a behavioural quadrature reader on the A/B lines.
module tb_quad_encoder_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  quad_encoder_tx_if bus ();

  quad_encoder_tx #(
    .PHASE_CYCLES (4),
    .DWELL_CYCLES (3),
    .POS_MAX      (19)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [1:0] ab;
  assign ab = {bus.A, bus.B};

  // Reader model: counts a detent when 11 is re-entered; also flags any double toggle
  int         rd_pos = 0;
  logic [1:0] rd_prev = 2'b11;
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_prev = 2'b11;
      rd_pos  = 0;
    end else if (ab != rd_prev) begin
      total++;
      if (ab == ~rd_prev) begin
        bad++;
        $display("FAIL ab_gray: A/B moved %b -> %b in one cycle, required one bit change", rd_prev, ab);
      end
      if (ab == 2'b11 && rd_prev == 2'b01) rd_pos = (rd_pos == 19) ? 0 : rd_pos + 1;
      else if (ab == 2'b11 && rd_prev == 2'b10) rd_pos = (rd_pos == 0) ? 19 : rd_pos - 1;
      rd_prev = ab;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic do_step(input logic d);
    int n = 0;
    @(negedge clk);
    while (!bus.step_ready && n < 40) begin @(negedge clk); n++; end
    bus.step_valid = 1'b1;
    bus.step_dir   = d;
    @(negedge clk);
    bus.step_valid = 1'b0;
    n = 0;
    while (!bus.step_ready && n < 40) begin @(negedge clk); n++; end
    if (!bus.step_ready) begin
      total++; bad++;
      $display("FAIL step_timeout: step_ready=%b after 40 clks, required 1", bus.step_ready);
    end
  endtask

  task automatic test_reset();
    bus.step_valid = 1'b0;
    bus.step_dir   = 1'b0;
    @(negedge clk);
    total += 4;
    if (ab !== 2'b11)         begin bad++; $display("FAIL rst_ab: got %b want 11", ab); end
    if (bus.pos !== 5'd0)     begin bad++; $display("FAIL rst_pos: got %0d want 0", bus.pos); end
    if (bus.step_ready !== 1) begin bad++; $display("FAIL rst_ready: got %b want 1", bus.step_ready); end
    if (bus.busy !== 0)       begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (ab !== 2'b11 || bus.pos !== 5'd0 || bus.step_ready !== 1'b1) begin
        bad++;
        $display("FAIL idle_hold: ab=%b pos=%0d ready=%b want 11/0/1", ab, bus.pos, bus.step_ready);
      end
    end
  endtask

  task automatic test_cw_step();
    logic [1:0] exp_ab;
    logic [4:0] exp_pos;
    @(negedge clk);
    bus.step_valid = 1'b1;
    bus.step_dir   = 1'b1;
    @(negedge clk);
    bus.step_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) @(negedge clk);
      exp_ab  = (k <= 4) ? 2'b10 : (k <= 8) ? 2'b00 : (k <= 12) ? 2'b01 : 2'b11;
      exp_pos = (k >= 13) ? 5'd1 : 5'd0;
      total += 3;
      if (ab !== exp_ab)       begin bad++; $display("FAIL cw_ab[%0d]: got %b want %b", k, ab, exp_ab); end
      if (bus.pos !== exp_pos) begin bad++; $display("FAIL cw_pos[%0d]: got %0d want %0d", k, bus.pos, exp_pos); end
      if (bus.step_ready !== (k == 16)) begin
        bad++; $display("FAIL cw_ready[%0d]: got %b want %b", k, bus.step_ready, (k == 16));
      end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_ab;
    logic [4:0] exp_pos;
    apply_reset();
    for (int i = 1; i <= 20; i++) begin
      do_step(1'b1);
      exp_pos = 5'(i % 20);
      total++;
      if (bus.pos !== exp_pos) begin bad++; $display("FAIL wrap_pos[%0d]: got %0d want %0d", i, bus.pos, exp_pos); end
    end
    @(negedge clk);
    bus.step_valid = 1'b1;
    bus.step_dir   = 1'b0;
    @(negedge clk);
    bus.step_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) @(negedge clk);
      exp_ab  = (k <= 4) ? 2'b01 : (k <= 8) ? 2'b00 : (k <= 12) ? 2'b10 : 2'b11;
      exp_pos = (k >= 13) ? 5'd19 : 5'd0;
      total += 2;
      if (ab !== exp_ab)       begin bad++; $display("FAIL ccw_ab[%0d]: got %b want %b", k, ab, exp_ab); end
      if (bus.pos !== exp_pos) begin bad++; $display("FAIL ccw_pos[%0d]: got %0d want %0d", k, bus.pos, exp_pos); end
    end
  endtask

  task automatic test_back_to_back();
    int         accepts = 0;
    int         model_pos = 19;
    logic       pend = 1'b0;
    logic       pend_dir = 1'b0;
    logic       di;
    logic [1:0] exp_ab;
    int         n = 0;
    @(negedge clk);
    bus.step_valid = 1'b1;
    for (int i = 0; i < 48; i++) begin
      if (pend) begin
        exp_ab = pend_dir ? 2'b10 : 2'b01;
        total++;
        if (ab !== exp_ab) begin bad++; $display("FAIL b2b_dir@%0d: ab=%b want %b", i, ab, exp_ab); end
        pend = 1'b0;
      end
      di = (i % 2 == 0);
      bus.step_dir = di;
      if (bus.step_ready) begin
        accepts++;
        pend = 1'b1;
        pend_dir = di;
        if (di) model_pos = (model_pos == 19) ? 0 : model_pos + 1;
        else    model_pos = (model_pos == 0) ? 19 : model_pos - 1;
      end
      @(negedge clk);
    end
    bus.step_valid = 1'b0;
    while (!bus.step_ready && n < 40) begin @(negedge clk); n++; end
    total += 2;
    if (accepts !== 3) begin bad++; $display("FAIL b2b_accepts: got %0d want 3", accepts); end
    if (bus.pos !== 5'(model_pos)) begin bad++; $display("FAIL b2b_pos: got %0d want %0d", bus.pos, model_pos); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    @(negedge clk);
    bus.step_valid = 1'b1;
    bus.step_dir   = 1'b1;
    @(negedge clk);
    bus.step_valid = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (ab !== 2'b00) begin bad++; $display("FAIL mid_in_ph2: ab=%b want 00", ab); end
    #2 rst_n = 1'b0;
    #1;
    total += 3;
    if (ab !== 2'b11)         begin bad++; $display("FAIL mid_rst_ab: got %b want 11", ab); end
    if (bus.pos !== 5'd0)     begin bad++; $display("FAIL mid_rst_pos: got %0d want 0", bus.pos); end
    if (bus.step_ready !== 1) begin bad++; $display("FAIL mid_rst_ready: got %b want 1", bus.step_ready); end
    @(negedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    total += 3;
    if (ab !== 2'b11)         begin bad++; $display("FAIL mid_post_ab: got %b want 11", ab); end
    if (bus.pos !== 5'd0)     begin bad++; $display("FAIL mid_post_pos: got %0d want 0", bus.pos); end
    if (bus.step_ready !== 1) begin bad++; $display("FAIL mid_post_ready: got %b want 1", bus.step_ready); end
  endtask

  task automatic test_loopback();
    for (int i = 0; i < 5; i++) do_step(1'b1);
    for (int i = 0; i < 2; i++) do_step(1'b0);
    @(negedge clk);
    total += 2;
    if (rd_pos !== 3)      begin bad++; $display("FAIL loop_reader: got %0d want 3", rd_pos); end
    if (bus.pos !== 5'd3)  begin bad++; $display("FAIL loop_pos: got %0d want 3", bus.pos); end
  endtask

  initial begin
    test_reset();
    test_cw_step();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
